// File: rtl/mealey_acc_arb_types.sv
`default_nettype none
// ============================================================================
// Module      : mealey_acc_arb_types (package)
// Description : Shared types and constants for the mealey_acc_arbiter slice.
//               DEF_* values are the default build parameters; the typedefs
//               and clamp bounds below are sized for that default build.
//               Optional feature macro: MEALEY_ACC_ARB_SAT_EN (saturating
//               accumulate in the top level).
// Contents    : DEF_N_REQ, DEF_WIDTH, DEF_ID_W, acc_t, id_t, ACC_MAX,
//               ACC_MIN, rsp_t
// Revision    : 1.0 - initial release
// ============================================================================
package mealey_acc_arb_types;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_WIDTH = 9;
   localparam int DEF_ID_W  = $clog2(DEF_N_REQ);

   typedef logic signed [DEF_WIDTH-1:0] acc_t;
   typedef logic        [DEF_ID_W-1:0]  id_t;

   localparam acc_t ACC_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
   localparam acc_t ACC_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

   typedef struct packed {
      logic valid;
      id_t  id;
      acc_t data;
      logic sat;
   } rsp_t;

endpackage
`default_nettype wire

// File: rtl/mealey_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mealey_rr_arbiter
// Description : Combinational round-robin arbiter. Candidates are scanned
//               from ptr+1 upward with modulo-N_REQ wrap; the first active
//               request wins.
// Ports       : req       - request vector
//               ptr       - index of the most recently served requester
//               grant     - one-hot grant (all zero when nothing requested)
//               grant_idx - binary index of the granted requester
//               any_grant - high when some request was granted
// Revision    : 1.0 - initial release
// ============================================================================
module mealey_rr_arbiter
   import mealey_acc_arb_types::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx,
   output logic             any_grant
);

   logic [ID_W-1:0] w_cand;

   // k runs 1..N_REQ so the last candidate examined is ptr itself, which
   // lets a sole requester keep the grant cycle after cycle.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      w_cand    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_cand = ID_W'((int'(ptr) + k) % N_REQ);
         if (!any_grant && req[w_cand]) begin
            grant[w_cand] = 1'b1;
            grant_idx     = w_cand;
            any_grant     = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mealey_acc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mealey_acc_arbiter
// Description : One signed accumulate datapath shared by N_REQ requesters,
//               each with its own accumulator context. A round-robin arbiter
//               grants one requester per cycle; the granted context is
//               updated and its pre-update value is returned one cycle later.
//               Optional macro MEALEY_ACC_ARB_SAT_EN: clamp the update to the
//               signed WIDTH range and report it on rsp_sat (otherwise the
//               add wraps and rsp_sat is 0).
// Ports       : system1000     - clock, rising edge
//               system1000_rst - asynchronous active-high reset
//               req_valid      - per-requester request valid
//               req_data       - per-requester signed operand, lane i at
//                                [i*WIDTH +: WIDTH]
//               req_clr        - per-requester clear-before-add
//               req_ready      - one-hot grant
//               rsp_valid      - response valid (one per accepted request)
//               rsp_id         - served requester index
//               rsp_data       - accumulator value before the update
//               rsp_sat        - clamp fired on the served update
// Revision    : 1.0 - initial release
// ============================================================================
module mealey_acc_arbiter
   import mealey_acc_arb_types::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   system1000,
   input  logic                   system1000_rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   input  logic [N_REQ-1:0]       req_clr,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   rsp_sat
);

   logic signed [WIDTH-1:0] r_acc [N_REQ];
   logic [ID_W-1:0]         r_rr_ptr;
   logic                    r_rsp_valid;
   logic [ID_W-1:0]         r_rsp_id;
   logic [WIDTH-1:0]        r_rsp_data;

   logic signed [WIDTH-1:0] w_lane [N_REQ];
   logic [N_REQ-1:0]        w_grant;
   logic [ID_W-1:0]         w_idx;
   logic                    w_any;
   logic                    w_xfer;
   logic signed [WIDTH-1:0] w_op;
   logic signed [WIDTH-1:0] w_old;
   logic signed [WIDTH-1:0] w_base;
   logic signed [WIDTH-1:0] w_new;

   genvar g;
   generate
      for (g = 0; g < N_REQ; g++) begin : g_lane
         assign w_lane[g] = req_data[g*WIDTH +: WIDTH];
      end
   endgenerate

   mealey_rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (r_rr_ptr),
      .grant     (w_grant),
      .grant_idx (w_idx),
      .any_grant (w_any)
   );

   // No grant is offered while reset is held, so a producer never sees a
   // handshake that the held-in-reset datapath would drop.
   assign req_ready = system1000_rst ? '0 : w_grant;
   assign w_xfer    = w_any & ~system1000_rst;

`ifdef MEALEY_ACC_ARB_SAT_EN
   localparam logic signed [WIDTH-1:0] c_ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] c_ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [WIDTH:0] w_wide;
   logic                  w_sat;
   logic                  r_rsp_sat;
`endif

   always_comb begin
      w_op   = w_lane[w_idx];
      w_old  = r_acc[w_idx];
      w_base = req_clr[w_idx] ? '0 : w_old;
`ifdef MEALEY_ACC_ARB_SAT_EN
      // One extra bit holds the exact sum; overflow shows as the top two
      // bits disagreeing, and the top bit then gives the direction.
      w_wide = {w_base[WIDTH-1], w_base} + {w_op[WIDTH-1], w_op};
      w_sat  = (w_wide[WIDTH] != w_wide[WIDTH-1]);
      if (w_sat) begin
         w_new = w_wide[WIDTH] ? c_ACC_MIN : c_ACC_MAX;
      end else begin
         w_new = w_wide[WIDTH-1:0];
      end
`else
      w_new  = w_base + w_op;
`endif
   end

   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            r_acc[i] <= '0;
         end
         r_rr_ptr    <= ID_W'(N_REQ - 1);
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= w_xfer;
         if (w_xfer) begin
            r_acc[w_idx] <= w_new;
            r_rr_ptr     <= w_idx;
            r_rsp_id     <= w_idx;
            r_rsp_data   <= w_old;
         end
      end
   end

`ifdef MEALEY_ACC_ARB_SAT_EN
   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         r_rsp_sat <= 1'b0;
      end else if (w_xfer) begin
         r_rsp_sat <= w_sat;
      end
   end

   assign rsp_sat = r_rsp_sat;
`else
   assign rsp_sat = 1'b0;
`endif

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: doc/mealey_acc_arbiter.md
Name: mealey_acc_arbiter

Overview:
Shares one signed accumulate datapath (state register + adder, Mealy output = pre-add state) among N_REQ requesters, each with its own accumulator context. A round-robin arbiter grants one requester per cycle and performs a single add on that requester's context. The registered response returns the requester's previous accumulator value. The block sits between N_REQ stream producers and the shared accumulate datapath.

Parameters:
N_REQ, 4, number of requesters/contexts (2..16)
WIDTH, 9, signed data and accumulator width in bits
ID_W, $clog2(N_REQ), width of the requester index

Ports:
system1000  input  1  clock, all state on rising edge
system1000_rst  input  1  reset, asynchronous, active-high
req_valid  input  N_REQ  per-requester request valid
req_data  input  N_REQ*WIDTH  signed operand; requester i occupies bits [i*WIDTH +: WIDTH]
req_clr  input  N_REQ  per-requester clear-before-add qualifier, sampled with valid
req_ready  output  N_REQ  one-hot grant; at most one bit set
rsp_valid  output  1  response valid, one cycle per accepted request
rsp_id  output  ID_W  index of the served requester
rsp_data  output  WIDTH  signed accumulator value before this request's update
rsp_sat  output  1  saturation flag (see Optional Feature)

Behaviour:
- Reset: all acc[i]=0, rr_ptr=N_REQ-1 (so requester 0 has priority first), rsp_valid=0, rsp_id=0, rsp_data=0, rsp_sat=0. Reset asserted mid-operation discards any in-flight response; the next cycle shows rsp_valid=0.
- Arbitration is combinational. Candidates are scanned from rr_ptr+1 upward with modulo N_REQ wrap. The first i with req_valid[i]=1 gets req_ready[i]=1. req_ready is 0 when no request is pending.
- Transfer occurs when req_valid[i] & req_ready[i]. At most one transfer per cycle.
- On transfer:
  - acc[i] <= (req_clr[i] ? 0 : acc[i]) + req_data[i]
  - rr_ptr <= i
  - Registered response next cycle: rsp_valid=1, rsp_id=i, rsp_data=old acc[i] (before any clear).
- Latency: exactly 1 cycle from transfer to response. Throughput: 1 per cycle. No backpressure on the response.
- No transfer: rr_ptr unchanged, rsp_valid=0. rsp_id and rsp_data hold their last values.
- Arithmetic: WIDTH-bit two's complement, wrap-around on overflow (e.g. 255+1 = -256).
- Requester i sees a request accepted only on a cycle where req_ready[i]=1. A request held low on valid is not remembered.
- Contexts not granted are unchanged. Back-to-back grants to the same requester use the updated acc value; no hazard is possible because acc is read and written in the same cycle.
- Fairness: with all N_REQ requesters continuously valid, each is served exactly once every N_REQ cycles.

Optional Feature:
- Macro: MEALEY_ACC_ARB_SAT_EN.
- Defined: the add is computed at WIDTH+1 bits and the stored result is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. rsp_sat is registered alongside the response and is 1 when the clamp fired on the served request's update.
- Undefined: wrap-around arithmetic applies and rsp_sat is tied to 0.
- The port list is identical in both builds.

Decomposition:
- Package mealey_acc_arb_types:
  - typedef acc_t (signed WIDTH)
  - typedef id_t
  - constants ACC_MAX and ACC_MIN
  - response struct {valid, id, data, sat}
- Sub-module mealey_rr_arbiter: inputs req vector and ptr; outputs one-hot grant, grant index, any_grant. Purely combinational.
- The accumulator context array, adder/clamp and response register live in the top.

Test Plan:
1. Reset, then req_valid=0001 with data 5, then 3 (2 cycles) -> req_ready=0001 both cycles; rsp_data 0 then 5; acc[0]=8.
2. req_valid=1111 held 8 cycles, all data=1 -> grants 0,1,2,3,0,1,2,3; rsp_data 0×4 then 1×4; rsp_id follows the grant one cycle later.
3. acc[2]=100, then a request with req_clr[2]=1 and data -7 -> rsp_data=100; the following request with data 0 returns -7.
4. acc[1]=250, add 10 -> without the macro, next rsp_data=-252 and rsp_sat=0; with MEALEY_ACC_ARB_SAT_EN, rsp_data=255 and rsp_sat=1. Also acc=-250, add -10 -> -256 in the saturating build.
5. Grant to requester 3 (rr_ptr=3), then only req_valid=1000 for 3 cycles -> requester 3 is granted every cycle; grant stays with the sole requester.
6. Assert system1000_rst asynchronously mid-stream with req_valid=1111 -> req_ready=0000 while reset is asserted; after release rsp_valid=0, requester 0 is granted first, and its rsp_data=0.
